// File: rtl/seq_acc_sched.sv
// seq_acc_sched: job-level controller feeding seq_acc and draining its results.
// Optional one-entry prefetch enabled by defining SEQ_ACC_SCHED_PREFETCH_EN.
module seq_acc_sched #(
    parameter int inputElements  = 128,
    parameter int inputBits      = 5,
    parameter int outputElements = 32,
    parameter int outputBits     = 4,
    parameter int addrBits       = 10,
    parameter int maxOutstanding = 2
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic                                 start_i,
    input  logic [addrBits-1:0]                  num_vec_i,
    input  logic [addrBits-1:0]                  in_base_i,
    input  logic [addrBits-1:0]                  out_base_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 err_o,
    output logic                                 act_rd_en_o,
    output logic [addrBits-1:0]                  act_rd_addr_o,
    input  logic [inputElements*inputBits-1:0]   act_rd_data_i,
    output logic [inputElements*inputBits-1:0]   mac_data_o,
    output logic                                 mac_valid_o,
    input  logic                                 mac_ready_i,
    input  logic                                 acc_valid_i,
    input  logic [outputElements*outputBits-1:0] acc_data_i,
    output logic                                 out_wr_en_o,
    output logic [addrBits-1:0]                  out_wr_addr_o,
    output logic [outputElements*outputBits-1:0] out_wr_data_o
);

    localparam int IW = inputElements * inputBits;
    localparam int OW = outputElements * outputBits;
    localparam int CW = addrBits + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_DRAIN, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         num_q, num_d;
    logic [addrBits-1:0]   in_base_q, in_base_d;
    logic [addrBits-1:0]   out_base_q, out_base_d;
    logic [CW-1:0]         issue_q, issue_d;
    logic [CW-1:0]         fetch_q, fetch_d;
    logic [CW-1:0]         ret_q, ret_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic                  err_q, err_d;
    logic [IW-1:0]         hold_q, hold_d;
`ifdef SEQ_ACC_SCHED_PREFETCH_EN
    logic [IW-1:0]         pf_q, pf_d;
    logic                  pf_valid_q, pf_valid_d;
    logic                  pend_q, pend_d;
`endif

    logic ret_ok;
    logic can_issue;
    logic hs;
    logic last;

    // Return-path qualification and issue gating against the outstanding cap.
    always_comb begin
        ret_ok    = acc_valid_i && (state_q != S_IDLE) && (outst_q != '0);
        can_issue = (outst_q < CW'(maxOutstanding)) ||
                    ((outst_q == CW'(maxOutstanding)) && ret_ok);
        mac_valid_o = (state_q == S_ISSUE) && can_issue;
        hs        = mac_valid_o && mac_ready_i;
        last      = (issue_q + CW'(1)) == num_q;
    end

    // Next-state logic, counters and the activation read strobe.
    always_comb begin
        state_d       = state_q;
        num_d         = num_q;
        in_base_d     = in_base_q;
        out_base_d    = out_base_q;
        issue_d       = issue_q;
        fetch_d       = fetch_q;
        ret_d         = ret_q + CW'(ret_ok);
        outst_d       = outst_q + CW'(hs) - CW'(ret_ok);
        err_d         = err_q | (acc_valid_i && !ret_ok);
        hold_d        = hold_q;
        act_rd_en_o   = 1'b0;
        act_rd_addr_o = '0;
`ifdef SEQ_ACC_SCHED_PREFETCH_EN
        pf_d          = pf_q;
        pf_valid_d    = pf_valid_q;
        if (state_q == S_ISSUE && !pf_valid_q && !pend_q &&
            fetch_q < num_q) begin
            act_rd_en_o   = 1'b1;
            act_rd_addr_o = in_base_q + fetch_q[addrBits-1:0];
            fetch_d       = fetch_q + CW'(1);
        end
        if (state_q == S_ISSUE && pend_q && !(hs && !last)) begin
            pf_d       = act_rd_data_i;
            pf_valid_d = 1'b1;
        end
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (num_vec_i != '0) begin
                        num_d      = {1'b0, num_vec_i};
                        in_base_d  = in_base_i;
                        out_base_d = out_base_i;
                        issue_d    = '0;
                        fetch_d    = '0;
                        ret_d      = '0;
                        outst_d    = '0;
`ifdef SEQ_ACC_SCHED_PREFETCH_EN
                        pf_valid_d = 1'b0;
`endif
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                act_rd_en_o   = 1'b1;
                act_rd_addr_o = in_base_q + fetch_q[addrBits-1:0];
                fetch_d       = fetch_q + CW'(1);
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                hold_d  = act_rd_data_i;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (hs) begin
                    issue_d = issue_q + CW'(1);
                    if (last) begin
                        state_d = S_DRAIN;
                    end else begin
`ifdef SEQ_ACC_SCHED_PREFETCH_EN
                        if (pf_valid_q) begin
                            hold_d     = pf_q;
                            pf_valid_d = 1'b0;
                        end else if (pend_q) begin
                            hold_d = act_rd_data_i;
                        end else begin
                            state_d = S_WAIT;
                        end
`else
                        state_d = S_FETCH;
`endif
                    end
                end
            end
            S_DRAIN: begin
                if (ret_q == num_q) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef SEQ_ACC_SCHED_PREFETCH_EN
        pend_d = act_rd_en_o;
`endif
    end

    // Output buffer write path and status outputs.
    always_comb begin
        busy_o        = state_q != S_IDLE;
        done_o        = state_q == S_DONE;
        err_o         = err_q;
        mac_data_o    = hold_q;
        out_wr_en_o   = ret_ok;
        out_wr_addr_o = '0;
        out_wr_data_o = '0;
        if (ret_ok) begin
            out_wr_addr_o = out_base_q + ret_q[addrBits-1:0];
            out_wr_data_o = acc_data_i;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
            issue_q    <= '0;
            fetch_q    <= '0;
            ret_q      <= '0;
            outst_q    <= '0;
            err_q      <= 1'b0;
            hold_q     <= '0;
`ifdef SEQ_ACC_SCHED_PREFETCH_EN
            pf_q       <= '0;
            pf_valid_q <= 1'b0;
            pend_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            in_base_q  <= in_base_d;
            out_base_q <= out_base_d;
            issue_q    <= issue_d;
            fetch_q    <= fetch_d;
            ret_q      <= ret_d;
            outst_q    <= outst_d;
            err_q      <= err_d;
            hold_q     <= hold_d;
`ifdef SEQ_ACC_SCHED_PREFETCH_EN
            pf_q       <= pf_d;
            pf_valid_q <= pf_valid_d;
            pend_q     <= pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_acc_sched.sv
// tb_seq_acc_sched: directed jobs against a behavioural activation buffer and
// seq_acc model; a monitor checks reads/writes against expectation queues.
module tb_seq_acc_sched;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          start_i = 1'b0;
    logic [9:0]    num_vec_i = '0;
    logic [9:0]    in_base_i = '0;
    logic [9:0]    out_base_i = '0;
    logic          busy_o, done_o, err_o;
    logic          act_rd_en_o;
    logic [9:0]    act_rd_addr_o;
    logic [639:0]  act_rd_data_i = '0;
    logic [639:0]  mac_data_o;
    logic          mac_valid_o;
    logic          mac_ready_i = 1'b1;
    logic          acc_valid_i = 1'b0;
    logic [127:0]  acc_data_i = '0;
    logic          out_wr_en_o;
    logic [9:0]    out_wr_addr_o;
    logic [127:0]  out_wr_data_o;

    seq_acc_sched dut (
        .clk(clk), .nrst(nrst), .start_i(start_i),
        .num_vec_i(num_vec_i), .in_base_i(in_base_i),
        .out_base_i(out_base_i), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .act_rd_en_o(act_rd_en_o),
        .act_rd_addr_o(act_rd_addr_o), .act_rd_data_i(act_rd_data_i),
        .mac_data_o(mac_data_o), .mac_valid_o(mac_valid_o),
        .mac_ready_i(mac_ready_i), .acc_valid_i(acc_valid_i),
        .acc_data_i(acc_data_i), .out_wr_en_o(out_wr_en_o),
        .out_wr_addr_o(out_wr_addr_o), .out_wr_data_o(out_wr_data_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [9:0] a; logic [127:0] d; } wr_t;
    typedef struct { logic [127:0] d; int due; } ent_t;

    logic [9:0] exp_rd[$];
    wr_t        exp_wr[$];
    ent_t       mq[$];

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    int same_cnt = 0;
    int cyc = 0;
    int lat = 6;
    int credits = -1;
    bit hold = 0;
    bit rdy_alt = 0;
    bit spur_req = 0;
    bit cur_spur = 0;

    function automatic logic [639:0] vec(input logic [9:0] a);
        return {64{a}};
    endfunction

    function automatic logic [127:0] res(input logic [9:0] a);
        logic [639:0] t;
        t = vec(a);
        return t[127:0];
    endfunction

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Activation buffer and seq_acc behavioural model.
    initial begin
        logic       s_rd, s_hs, s_ret;
        logic [9:0] s_ra;
        logic [127:0] s_hd;
        forever begin
            @(negedge clk);
            cyc++;
            s_rd  = act_rd_en_o;
            s_ra  = act_rd_addr_o;
            s_hs  = mac_valid_o && mac_ready_i;
            s_hd  = mac_data_o[127:0];
            s_ret = acc_valid_i && !cur_spur;
            if (s_hs) hs_cnt++;
            if (mac_valid_o && mac_ready_i && acc_valid_i) same_cnt++;
            @(posedge clk);
            #1;
            if (!nrst) begin
                mq.delete();
                acc_valid_i = 1'b0;
                cur_spur = 0;
            end else begin
                if (s_rd) act_rd_data_i = vec(s_ra);
                if (s_ret && mq.size() > 0) void'(mq.pop_front());
                if (s_hs) mq.push_back('{s_hd, cyc + lat});
                if (s_hs && credits > 0) credits--;
                acc_valid_i = 1'b0;
                cur_spur = 0;
                if (spur_req) begin
                    acc_valid_i = 1'b1;
                    acc_data_i  = 128'hDEAD_BEEF;
                    cur_spur    = 1;
                    spur_req    = 0;
                end else if (mq.size() > 0 && mq[0].due <= cyc && !hold) begin
                    acc_valid_i = 1'b1;
                    acc_data_i  = mq[0].d;
                end
                mac_ready_i = rdy_alt ? ~mac_ready_i : (credits != 0);
            end
        end
    end

    // Scoreboard monitor: pops expectations whenever the DUT reads or writes.
    initial begin
        wr_t w;
        logic [9:0] a;
        forever begin
            @(negedge clk);
            if (act_rd_en_o) begin
                if (exp_rd.size() == 0) begin
                    check("rd_unexpected", 128'(act_rd_addr_o), 128'h3FFF);
                end else begin
                    a = exp_rd.pop_front();
                    check("rd_addr", 128'(act_rd_addr_o), 128'(a));
                end
            end
            if (out_wr_en_o) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", 128'(out_wr_addr_o), 128'h3FFF);
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", 128'(out_wr_addr_o), 128'(w.a));
                    check("wr_data", out_wr_data_o, w.d);
                end
            end
            if (done_o) done_cnt++;
        end
    end

    task automatic push_exp(input logic [9:0] n, input logic [9:0] ib,
                            input logic [9:0] ob);
        logic [9:0] ra, wa;
        for (int k = 0; k < int'(n); k++) begin
            ra = ib + 10'(k);
            wa = ob + 10'(k);
            exp_rd.push_back(ra);
            exp_wr.push_back('{wa, res(ra)});
        end
    endtask

    task automatic start_job(input logic [9:0] n, input logic [9:0] ib,
                             input logic [9:0] ob);
        @(posedge clk);
        #1;
        start_i = 1'b1;
        num_vec_i = n;
        in_base_i = ib;
        out_base_i = ob;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0, input int maxc);
        bit seen;
        seen = 0;
        for (int k = 0; k < maxc && !seen; k++) begin
            @(negedge clk);
            if (done_cnt > d0 || done_o) seen = 1;
        end
        if (!seen) check({name, "_timeout"}, 128'(0), 128'(1));
        repeat (3) @(negedge clk);
        check({name, "_done_once"}, 128'(done_cnt - d0), 128'(1));
        check({name, "_idle"}, 128'(busy_o), 128'(0));
        check({name, "_rdq"}, 128'(exp_rd.size()), 128'(0));
        check({name, "_wrq"}, 128'(exp_wr.size()), 128'(0));
    endtask

    task automatic wait_cond_hs(input int target, input int maxc);
        bit seen;
        seen = 0;
        for (int k = 0; k < maxc && !seen; k++) begin
            @(negedge clk);
            if (hs_cnt >= target) seen = 1;
        end
        if (!seen) check("hs_timeout", 128'(hs_cnt), 128'(target));
    endtask

    initial begin
        int d0, h0, s0;
        bit seen;
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy_o), 128'(0));
        check("rst_done", 128'(done_o), 128'(0));
        check("rst_err", 128'(err_o), 128'(0));
        check("rst_rd_en", 128'(act_rd_en_o), 128'(0));
        check("rst_mac_valid", 128'(mac_valid_o), 128'(0));
        check("rst_wr_en", 128'(out_wr_en_o), 128'(0));
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Wrapping addresses, latency 6.
        lat = 6;
        push_exp(10'd4, 10'h3FE, 10'h3FF);
        d0 = done_cnt;
        start_job(10'd4, 10'h3FE, 10'h3FF);
        check("job_busy", 128'(busy_o), 128'(1));
        wait_done("wrap", d0, 200);
        check("wrap_err", 128'(err_o), 128'(0));

        // Zero-length job.
        d0 = done_cnt;
        start_job(10'd0, 10'h123, 10'h045);
        wait_done("zero", d0, 3);

        // Alternating ready.
        rdy_alt = 1;
        lat = 3;
        push_exp(10'd3, 10'h0F0, 10'h300);
        d0 = done_cnt;
        start_job(10'd3, 10'h0F0, 10'h300);
        wait_done("alt", d0, 200);
        rdy_alt = 0;
        @(posedge clk);
        #2;
        mac_ready_i = 1'b1;

        // Results held: issue stalls at the outstanding cap.
        hold = 1;
        lat = 1;
        h0 = hs_cnt;
        s0 = same_cnt;
        push_exp(10'd3, 10'h010, 10'h020);
        d0 = done_cnt;
        start_job(10'd3, 10'h010, 10'h020);
        repeat (20) @(negedge clk);
        check("cap_issued", 128'(hs_cnt - h0), 128'(2));
        check("cap_valid_low", 128'(mac_valid_o), 128'(0));
        hold = 0;
        wait_done("cap", d0, 100);
        check("cap_same_cycle", 128'(same_cnt > s0), 128'(1));
        check("cap_total", 128'(hs_cnt - h0), 128'(3));

        // Spurious result in IDLE.
        spur_req = 1;
        repeat (3) @(negedge clk);
        check("spur_err", 128'(err_o), 128'(1));
        push_exp(10'd1, 10'h005, 10'h006);
        d0 = done_cnt;
        lat = 2;
        start_job(10'd1, 10'h005, 10'h006);
        @(negedge clk);
        check("spur_err_clr", 128'(err_o), 128'(0));
        wait_done("spur", d0, 100);

        // start_i while busy is ignored.
        lat = 4;
        push_exp(10'd3, 10'h100, 10'h200);
        d0 = done_cnt;
        start_job(10'd3, 10'h100, 10'h200);
        repeat (3) @(negedge clk);
        start_job(10'd5, 10'h2AA, 10'h155);
        wait_done("busy_start", d0, 200);

        // Reset mid-job while in ISSUE with one outstanding.
        hold = 1;
        credits = 1;
        @(posedge clk);
        #2;
        mac_ready_i = 1'b1;
        h0 = hs_cnt;
        exp_rd.push_back(10'h040);
        exp_rd.push_back(10'h041);
        start_job(10'd2, 10'h040, 10'h050);
        wait_cond_hs(h0 + 1, 100);
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (mac_valid_o) seen = 1;
        end
        check("mid_reached_issue", 128'(seen), 128'(1));
        nrst = 1'b0;
        #1;
        check("mid_busy", 128'(busy_o), 128'(0));
        check("mid_done", 128'(done_o), 128'(0));
        check("mid_err", 128'(err_o), 128'(0));
        check("mid_rd", {act_rd_en_o, act_rd_addr_o}, 128'(0));
        check("mid_mac", {mac_valid_o, mac_data_o[127:0]}, 128'(0));
        check("mid_wr", {out_wr_en_o, out_wr_addr_o}, 128'(0));
        check("mid_wr_data", out_wr_data_o, 128'(0));
        exp_rd.delete();
        exp_wr.delete();
        repeat (2) @(negedge clk);
        credits = -1;
        hold = 0;
        nrst = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_idle", 128'(busy_o), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
